// File: rtl/bus_req_arbiter.sv
// Round-robin bus request arbiter: IDLE -> PRESENT -> BUSY.
// Optional watchdog built only when ARB_WDOG_EN is defined.
module bus_req_arbiter #(
  parameter int NUM_CPUS    = 8,
  parameter int ADDR_W      = 32,
  parameter int WDOG_CYCLES = 10000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CPUS-1:0]          cache_req,
  input  logic [2*NUM_CPUS-1:0]        cache_req_type,
  input  logic [ADDR_W*NUM_CPUS-1:0]   cache_req_addr,
  output logic [NUM_CPUS-1:0]          cache_gnt,
  output logic                         bus_req_valid,
  output logic [$clog2(NUM_CPUS)-1:0]  bus_req_id,
  output logic [1:0]                   bus_req_type,
  output logic [ADDR_W-1:0]            bus_req_addr,
  input  logic                         bus_ready,
  input  logic                         bus_done,
  output logic                         arb_err
);

  localparam int IDW = $clog2(NUM_CPUS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_BUSY
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [1:0]          type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_CPUS-1:0] gnt;

  logic                sel_found;
  logic [IDW-1:0]      sel_id;
  logic [1:0]          sel_type;
  logic [ADDR_W-1:0]   sel_addr;
  logic [IDW-1:0]      rr_next;

  // First requester at or after rr_q, wrapping to the lowest index.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (!sel_found && cache_req[i] && (IDW'(i) >= rr_q)) begin
        sel_found = 1'b1;
        sel_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (!sel_found && cache_req[i]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(i);
      end
    end
  end

  // Mux out the winning requester's type and address.
  always_comb begin
    sel_type = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (IDW'(i) == sel_id) begin
        sel_type = cache_req_type[2*i +: 2];
        sel_addr = cache_req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  assign rr_next = (id_q == IDW'(NUM_CPUS-1)) ? '0
                 : id_q + 1'b1;

`ifdef ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic          wdog_hit;

  assign wdog_hit = (state_q != S_IDLE) &&
                    (wcnt_q == CW'(WDOG_CYCLES - 1));
`endif

  // Next-state, pointer update and grant pulse.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    type_d  = type_q;
    addr_d  = addr_q;
    gnt     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          id_d    = sel_id;
          type_d  = sel_type;
          addr_d  = sel_addr;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus_ready) begin
          gnt[id_q] = 1'b1;
          rr_d      = rr_next;
          state_d   = bus_done ? S_IDLE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ARB_WDOG_EN
    err_d = err_q;
    if (wdog_hit) begin
      state_d = S_IDLE;
      rr_d    = rr_q;
      gnt     = '0;
      err_d   = 1'b1;
    end
    wcnt_d = '0;
    if ((state_q != S_IDLE) && (state_d != S_IDLE)) begin
      wcnt_d = wcnt_q + 1'b1;
    end
`endif
  end

  // State and latched-request registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      type_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
    end
  end

`ifdef ARB_WDOG_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  assign arb_err = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES > 0);
  assign arb_err     = 1'b0;
`endif

  assign cache_gnt     = RST ? '0 : gnt;
  assign bus_req_valid = (state_q == S_PRESENT);
  assign bus_req_id    = id_q;
  assign bus_req_type  = type_q;
  assign bus_req_addr  = addr_q;

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Bench for bus_req_arbiter: vector table plus reset,
// ignore and watchdog sequences, scoreboarded grants.
module tb_bus_req_arbiter;

  localparam int N  = 8;
  localparam int AW = 32;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    cache_req;
  logic [2*N-1:0]  cache_req_type;
  logic [AW*N-1:0] cache_req_addr;
  logic [N-1:0]    cache_gnt;
  logic            bus_req_valid;
  logic [2:0]      bus_req_id;
  logic [1:0]      bus_req_type;
  logic [AW-1:0]   bus_req_addr;
  logic            bus_ready;
  logic            bus_done;
  logic            arb_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  mask;
    logic [1:0]  typ;
    logic [31:0] base;
    logic [2:0]  exp_id;
    int          rdly;
    int          ddly;
    bit          drop;
  } vec_t;

  typedef struct {
    logic [2:0]  id;
    logic [1:0]  typ;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[16];

  bus_req_arbiter #(
    .NUM_CPUS(N),
    .ADDR_W(AW),
    .WDOG_CYCLES(20)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .cache_req(cache_req),
    .cache_req_type(cache_req_type),
    .cache_req_addr(cache_req_addr),
    .cache_gnt(cache_gnt),
    .bus_req_valid(bus_req_valid),
    .bus_req_id(bus_req_id),
    .bus_req_type(bus_req_type),
    .bus_req_addr(bus_req_addr),
    .bus_ready(bus_ready),
    .bus_done(bus_done),
    .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    checks++;
    if ($countones(cache_gnt) > 1) begin
      errors++;
      $display("FAIL gnt_onehot: got %0h required at most one bit",
               cache_gnt);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input logic [7:0] mask,
                           input logic [1:0] typ,
                           input logic [31:0] base);
    cache_req = mask;
    for (int i = 0; i < N; i++) begin
      cache_req_type[2*i +: 2] = typ + 2'(i);
      cache_req_addr[AW*i +: AW] = base + 32'(i) * 32'h40;
    end
  endtask

  task automatic push_exp(input logic [2:0] id,
                          input logic [1:0] typ,
                          input logic [31:0] base);
    exp_t e;
    e.id   = id;
    e.typ  = typ + 2'(id);
    e.addr = base + 32'(id) * 32'h40;
    sb.push_back(e);
  endtask

  task automatic present_pop(output exp_t e);
    chk("valid_latency", 64'(bus_req_valid), 64'd1);
    e.id = '0; e.typ = '0; e.addr = '0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got 0 entries required 1");
    end else begin
      e = sb.pop_front();
      chk("req_id", 64'(bus_req_id), 64'(e.id));
      chk("req_type", 64'(bus_req_type), 64'(e.typ));
      chk("req_addr", 64'(bus_req_addr), 64'(e.addr));
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    logic [7:0] oh;
    drive_req(v.mask, v.typ, v.base);
    bus_ready = 1'b0;
    bus_done  = 1'b0;
    push_exp(v.exp_id, v.typ, v.base);
    step();
    present_pop(e);
    if (v.drop) cache_req = '0;
    repeat (v.rdly) step();
    if (v.rdly > 0) begin
      chk("hold_valid", 64'(bus_req_valid), 64'd1);
      chk("hold_id", 64'(bus_req_id), 64'(e.id));
      chk("hold_addr", 64'(bus_req_addr), 64'(e.addr));
      chk("no_early_gnt", 64'(cache_gnt), 64'd0);
    end
    bus_ready = 1'b1;
    bus_done  = (v.ddly == 0);
    #1;
    oh = 8'h01;
    oh = oh << v.exp_id;
    chk("gnt", 64'(cache_gnt), 64'(oh));
    step();
    bus_ready = 1'b0;
    bus_done  = 1'b0;
    if (v.ddly == 0) begin
      chk("no_busy_valid", 64'(bus_req_valid), 64'd0);
    end else begin
      for (int d = 1; d < v.ddly; d++) begin
        chk("busy_valid", 64'(bus_req_valid), 64'd0);
        chk("busy_gnt", 64'(cache_gnt), 64'd0);
        step();
      end
      bus_done = 1'b1;
      step();
      bus_done = 1'b0;
      chk("idle_valid", 64'(bus_req_valid), 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(cache_gnt), 64'd0);
    chk({tag, "_valid"}, 64'(bus_req_valid), 64'd0);
    chk({tag, "_id"}, 64'(bus_req_id), 64'd0);
    chk({tag, "_type"}, 64'(bus_req_type), 64'd0);
    chk({tag, "_addr"}, 64'(bus_req_addr), 64'd0);
    chk({tag, "_err"}, 64'(arb_err), 64'd0);
  endtask

  initial begin
    exp_t e;
    vec_t v;

    tbl[0]  = '{8'h01, 2'd1, 32'h100,  3'd0, 0, 2, 1'b0};
    tbl[1]  = '{8'hFF, 2'd0, 32'h2000, 3'd1, 0, 0, 1'b0};
    tbl[2]  = '{8'hFF, 2'd2, 32'h2000, 3'd2, 0, 0, 1'b0};
    tbl[3]  = '{8'hFF, 2'd3, 32'h2400, 3'd3, 2, 0, 1'b0};
    tbl[4]  = '{8'hFF, 2'd0, 32'h2000, 3'd4, 0, 0, 1'b0};
    tbl[5]  = '{8'hFF, 2'd1, 32'h2800, 3'd5, 0, 0, 1'b0};
    tbl[6]  = '{8'hFF, 2'd0, 32'h2000, 3'd6, 1, 3, 1'b0};
    tbl[7]  = '{8'hFF, 2'd2, 32'h2000, 3'd7, 0, 0, 1'b0};
    tbl[8]  = '{8'hFF, 2'd0, 32'h2C00, 3'd0, 0, 0, 1'b0};
    tbl[9]  = '{8'h10, 2'd1, 32'h3000, 3'd4, 0, 0, 1'b0};
    tbl[10] = '{8'h21, 2'd2, 32'h3400, 3'd5, 0, 1, 1'b0};
    tbl[11] = '{8'h21, 2'd3, 32'h3800, 3'd0, 0, 0, 1'b0};
    tbl[12] = '{8'h80, 2'd0, 32'h4000, 3'd7, 3, 1, 1'b0};
    tbl[13] = '{8'h06, 2'd1, 32'h4400, 3'd1, 0, 0, 1'b0};
    tbl[14] = '{8'h08, 2'd2, 32'h4800, 3'd3, 2, 0, 1'b1};
    tbl[15] = '{8'h06, 2'd3, 32'h4C00, 3'd1, 0, 2, 1'b0};

    RST            = 1'b1;
    cache_req      = '0;
    cache_req_type = '0;
    cache_req_addr = '0;
    bus_ready      = 1'b0;
    bus_done       = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    RST = 1'b0;

    for (int k = 0; k < 16; k++) begin
      run_vec(tbl[k]);
    end

    // ready/done while idle must be ignored; rr_ptr is 2 here
    cache_req = '0;
    bus_ready = 1'b1;
    bus_done  = 1'b1;
    step();
    step();
    chk("idle_ready_valid", 64'(bus_req_valid), 64'd0);
    chk("idle_ready_gnt", 64'(cache_gnt), 64'd0);
    bus_ready = 1'b0;
    bus_done  = 1'b0;
    v = '{8'h44, 2'd0, 32'h5000, 3'd2, 0, 0, 1'b0};
    run_vec(v);

    // reset while presenting with ready high: no grant pulse
    drive_req(8'h40, 2'd1, 32'h6000);
    push_exp(3'd6, 2'd1, 32'h6000);
    step();
    present_pop(e);
    bus_ready = 1'b1;
    RST       = 1'b1;
    #1;
    chk("rst_present_gnt", 64'(cache_gnt), 64'd0);
    step();
    RST       = 1'b0;
    bus_ready = 1'b0;
    cache_req = '0;
    chk_all_zero("rst_present");

    // reset while busy aborts; rr_ptr returns to 0
    drive_req(8'h40, 2'd2, 32'h7000);
    push_exp(3'd6, 2'd2, 32'h7000);
    step();
    present_pop(e);
    bus_ready = 1'b1;
    #1;
    chk("busy_pre_gnt", 64'(cache_gnt), 64'h40);
    step();
    bus_ready = 1'b0;
    cache_req = '0;
    RST       = 1'b1;
    step();
    RST = 1'b0;
    chk_all_zero("rst_busy");
    v = '{8'h84, 2'd1, 32'h8000, 3'd2, 0, 1, 1'b0};
    run_vec(v);

    // withhold bus_ready to exercise the watchdog
    drive_req(8'h01, 2'd0, 32'h9000);
    push_exp(3'd0, 2'd0, 32'h9000);
    step();
    present_pop(e);
`ifdef ARB_WDOG_EN
    repeat (19) step();
    chk("wdog_pre_err", 64'(arb_err), 64'd0);
    chk("wdog_pre_valid", 64'(bus_req_valid), 64'd1);
    step();
    cache_req = '0;
    chk("wdog_err", 64'(arb_err), 64'd1);
    chk("wdog_idle", 64'(bus_req_valid), 64'd0);
    repeat (5) step();
    chk("wdog_sticky", 64'(arb_err), 64'd1);
`else
    repeat (25) step();
    chk("nowdog_err", 64'(arb_err), 64'd0);
    chk("nowdog_valid", 64'(bus_req_valid), 64'd1);
    bus_ready = 1'b1;
    bus_done  = 1'b1;
    #1;
    chk("nowdog_gnt", 64'(cache_gnt), 64'h01);
    step();
    bus_ready = 1'b0;
    bus_done  = 1'b0;
    cache_req = '0;
    chk("nowdog_end_err", 64'(arb_err), 64'd0);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
